wb_spi_mode: RTL and testbench

WB_SPI_MODE -- requirements
Module: wb_spi_mode

---
 rtl/wb_spi_mode.sv | 226 ++++++++++++++++++++++
 tb/tb_wb_spi_mode.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_mode.sv
// wb_spi_mode: Wishbone-attached SPI master with selectable mode and bit order.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   wb_adr_i..wb_ack_o  - Wishbone slave; word registers decoded from adr[4:2]
//                         0x00 DATA (wr: TX + start, rd: RX)
//                         0x04 STATUS (bit0 busy, bit1 done, sticky)
//                         0x08 CS
//                         0x0C CTRL (bit0 cpol, bit1 cpha, bit2 lsb_first,
//                                    bit3 irq enable, bits[12:8] len)
//                         0x10 DIV
//   spi_sck, spi_mosi   - SPI clock and data out (registered)
//   spi_miso            - SPI data in
//   spi_cs              - chip selects, straight from the CS register
//   irq                 - done & irq enable; present only when the macro
//                         WB_SPI_MODE_IRQ_EN is defined (otherwise CTRL bit3
//                         reads 0 and ignores writes)
module wb_spi_mode #(
    parameter int DATA_W = 8,
    parameter int CS_W   = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    output logic              wb_ack_o,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [CS_W-1:0]   spi_cs
`ifdef WB_SPI_MODE_IRQ_EN
    ,
    output logic              irq
`endif
);

    typedef enum logic [1:0] {IDLE, LEAD, TRAIL} state_t;

    state_t            state;
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] rx;
    logic [CS_W-1:0]   cs;
    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  pre;
    logic              cpol, cpha, lsb_first, irq_en;
    logic [4:0]        len;
    logic [4:0]        idx;
    logic [4:0]        bit_cnt;
    logic              done, ack, sck, mosi;
    logic              access, busy, half_end, last_bit;
    logic [2:0]        reg_sel;
    logic [31:0]       rdata;
    logic              unused_bits;

    // Index of the last bit of a transfer; len values past the register
    // width clamp to a full-width transfer.
    function automatic logic [4:0] sat_len(input logic [4:0] l);
        if ({1'b0, l} >= 6'(DATA_W)) return 5'(DATA_W - 1);
        return l;
    endfunction

    // Next outgoing bit: bit 0 when LSB first, otherwise bit i (top of the
    // active length).
    function automatic logic pick_bit(input logic [DATA_W-1:0] d, input logic lsb,
                                      input logic [4:0] i);
        logic [DATA_W-1:0] s;
        s = d >> i;
        return lsb ? d[0] : s[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d,
                                                    input logic lsb);
        return lsb ? (d >> 1) : (d << 1);
    endfunction

    // MSB first: shift in at bit 0. LSB first: shift right and insert at the
    // top of the active length, so the result ends up right-aligned.
    function automatic logic [DATA_W-1:0] rx_in(input logic [DATA_W-1:0] r, input logic b,
                                                input logic lsb, input logic [4:0] i);
        if (lsb) return (r >> 1) | ({{(DATA_W-1){1'b0}}, b} << i);
        return {r[DATA_W-2:0], b};
    endfunction

    // A new access is one not already being acknowledged; a held strobe
    // keeps ack high and produces no further side effects.
    assign access   = wb_cyc_i & wb_stb_i & ~ack;
    assign reg_sel  = wb_adr_i[4:2];
    assign busy     = (state != IDLE);
    assign idx      = sat_len(len);
    assign half_end = busy && (pre >= div);
    assign last_bit = (bit_cnt == idx);

    assign wb_ack_o = ack & wb_cyc_i & wb_stb_i;
    assign spi_sck  = sck;
    assign spi_mosi = mosi;
    assign spi_cs   = cs;

`ifdef WB_SPI_MODE_IRQ_EN
    assign irq = done & irq_en;
`else
    assign irq_en = 1'b0;
`endif

    assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_sel_i, wb_dat_i[31:13]};

    always_comb begin
        rdata = '0;
        case (reg_sel)
            3'd0:    rdata = 32'(rx);
            3'd1:    rdata = {30'd0, done, busy};
            3'd2:    rdata = 32'(cs);
            3'd3:    rdata = {19'd0, len, 4'd0, irq_en, lsb_first, cpha, cpol};
            3'd4:    rdata = 32'(div);
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= '0;
            rx        <= '0;
            cs        <= '1;
            div       <= '1;
            pre       <= '0;
            cpol      <= 1'b0;
            cpha      <= 1'b0;
            lsb_first <= 1'b0;
            len       <= 5'd7;
`ifdef WB_SPI_MODE_IRQ_EN
            irq_en    <= 1'b0;
`endif
            bit_cnt   <= '0;
            done      <= 1'b0;
            ack       <= 1'b0;
            wb_dat_o  <= '0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
        end else begin
            ack <= wb_cyc_i & wb_stb_i;

            if (access && !wb_we_i) begin
                wb_dat_o <= rdata;
                if (reg_sel == 3'd1) done <= 1'b0;
            end

            if (access && wb_we_i) begin
                case (reg_sel)
                    3'd2: cs  <= wb_dat_i[CS_W-1:0];
                    3'd4: div <= wb_dat_i[DIV_W-1:0];
                    3'd3: if (!busy) begin
                        cpol      <= wb_dat_i[0];
                        cpha      <= wb_dat_i[1];
                        lsb_first <= wb_dat_i[2];
`ifdef WB_SPI_MODE_IRQ_EN
                        irq_en    <= wb_dat_i[3];
`endif
                        len       <= wb_dat_i[12:8];
                    end
                    default: ;
                endcase
            end

            // Shift/sample events sit on half-period boundaries; which
            // boundary does which depends on cpha. done is set after the
            // STATUS-read clear above so a coinciding set wins.
            case (state)
                IDLE: begin
                    sck     <= cpol;
                    pre     <= '0;
                    bit_cnt <= '0;
                    if (access && wb_we_i && reg_sel == 3'd0) begin
                        state <= LEAD;
                        rx    <= '0;
                        mosi  <= pick_bit(wb_dat_i[DATA_W-1:0], lsb_first, idx);
                        tx    <= cpha ? wb_dat_i[DATA_W-1:0]
                                      : shift_out(wb_dat_i[DATA_W-1:0], lsb_first);
                    end
                end
                LEAD: begin
                    if (half_end) begin
                        state <= TRAIL;
                        sck   <= ~sck;
                        pre   <= '0;
                        if (cpha) begin
                            mosi <= pick_bit(tx, lsb_first, idx);
                            tx   <= shift_out(tx, lsb_first);
                        end else begin
                            rx <= rx_in(rx, spi_miso, lsb_first, idx);
                        end
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end
                TRAIL: begin
                    if (half_end) begin
                        sck <= ~sck;
                        pre <= '0;
                        if (cpha) rx <= rx_in(rx, spi_miso, lsb_first, idx);
                        if (last_bit) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state   <= LEAD;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (!cpha) begin
                                mosi <= pick_bit(tx, lsb_first, idx);
                                tx   <= shift_out(tx, lsb_first);
                            end
                        end
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_spi_mode.sv
// Directed testbench for wb_spi_mode: register access, SPI modes, bit order,
// length saturation, busy-write handling, mid-transfer reset and ack timing.
module tb_wb_spi_mode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
    logic        spi_sck, spi_mosi, spi_miso;
    logic [7:0]  spi_cs;
    logic        miso_loop, miso_val;
`ifdef WB_SPI_MODE_IRQ_EN
    logic        irq;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic        exp_bits[$];
    logic        got_bits[$];
    int          lead_times[$];
    int          cyc_cnt  = 0;
    logic        prev_sck = 1'b0;
    logic        mon_cpol = 1'b0;
    logic        mon_cpha = 1'b0;

    assign spi_miso = miso_loop ? spi_mosi : miso_val;

    wb_spi_mode #(.DATA_W(8), .CS_W(8), .DIV_W(8)) dut (
        .clk(clk), .reset(reset),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs(spi_cs)
`ifdef WB_SPI_MODE_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    // SPI monitor: logs each leading sck edge and the mosi bit at the
    // capture edge of the current mode.
    always @(negedge clk) begin
        cyc_cnt  <= cyc_cnt + 1;
        prev_sck <= spi_sck;
        if (spi_sck !== prev_sck) begin
            if (spi_sck !== mon_cpol) begin
                lead_times.push_back(cyc_cnt);
                if (!mon_cpha) got_bits.push_back(spi_mosi);
            end else if (mon_cpha) begin
                got_bits.push_back(spi_mosi);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            output logic [31:0] rd, output logic ok);
        ok = 1'b0;
        rd = '0;
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (wb_ack_o) begin
                ok = 1'b1;
                rd = wb_dat_o;
                break;
            end
        end
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] r;
        logic        ok;
        wb_cycle(1'b1, adr, dat, r, ok);
        check("wr_ack", {31'd0, ok}, 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        logic        ok;
        exp_q.push_back(exp);
        wb_cycle(1'b0, adr, 32'd0, r, ok);
        check({tag, "_ack"}, {31'd0, ok}, 32'd1);
        check(tag, r, exp_q.pop_front());
    endtask

    // Poll STATUS until busy clears; the final read must show done only.
    task automatic wait_idle(input string tag);
        logic [31:0] r;
        logic        ok;
        r = 32'h1;
        for (int i = 0; i < 200; i++) begin
            wb_cycle(1'b0, 32'h04, 32'd0, r, ok);
            if (!ok || r[0] == 1'b0) break;
        end
        exp_q.push_back(32'h2);
        check(tag, r, exp_q.pop_front());
    endtask

    task automatic wait_pulses(input int base, input int n, input int limit);
        int k;
        k = 0;
        while ((lead_times.size() - base) < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("pulse_wait", {31'd0, (lead_times.size() - base) >= n}, 32'd1);
    endtask

    task automatic push_bits(input logic [7:0] d, input int n, input logic lsb);
        for (int i = 0; i < n; i++) exp_bits.push_back(lsb ? d[i] : d[n-1-i]);
    endtask

    task automatic cmp_bits(input string tag, input int base, input int n);
        logic e, g;
        for (int i = 0; i < n; i++) begin
            e = exp_bits.pop_front();
            g = (got_bits.size() > base + i) ? got_bits[base + i] : 1'bx;
            check(tag, {31'd0, g}, {31'd0, e});
        end
    endtask

    initial begin
        int pb, gb;
        reset = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        miso_loop = 1'b1; miso_val = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_sck", {31'd0, spi_sck}, 32'd0);
        check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        check("rst_cs", {24'd0, spi_cs}, 32'hFF);
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_dat_o", wb_dat_o, 32'd0);
        rd_chk("rst_ctrl", 32'h0C, 32'h0700);
        rd_chk("rst_div", 32'h10, 32'hFF);
        rd_chk("rst_status", 32'h04, 32'h0);
        rd_chk("rst_data", 32'h00, 32'h0);
        rd_chk("rst_csreg", 32'h08, 32'hFF);

        // CS register and unmapped offsets
        wr(32'h08, 32'hFE);
        check("cs_port", {24'd0, spi_cs}, 32'hFE);
        rd_chk("cs_read", 32'h08, 32'hFE);
        wr(32'h18, 32'hFFFF_FFFF);
        rd_chk("unmapped_rd", 32'h18, 32'h0);
        rd_chk("ctrl_after_unmapped", 32'h0C, 32'h0700);

        // Mode 0, DIV=1, 8 bits MSB first, loopback
        wr(32'h10, 32'd1);
        wr(32'h0C, 32'h0700);
        miso_loop = 1'b1;
        pb = lead_times.size(); gb = got_bits.size();
        push_bits(8'hA5, 8, 1'b0);
        wr(32'h00, 32'hA5);
        wait_idle("m0_done");
        check("m0_pulses", 32'(lead_times.size() - pb), 32'd8);
        check("m0_period", 32'(lead_times[pb+1] - lead_times[pb]), 32'd4);
        check("m0_span", 32'(lead_times[pb+7] - lead_times[pb]), 32'd28);
        cmp_bits("m0_mosi", gb, 8);
        check("m0_sck_idle", {31'd0, spi_sck}, 32'd0);
        rd_chk("m0_rx", 32'h00, 32'hA5);
        rd_chk("m0_status_clr", 32'h04, 32'h0);

        // Mode 3, LSB first, 4 bits, miso tied high
        wr(32'h0C, 32'h0307);
        rd_chk("m3_ctrl", 32'h0C, 32'h0307);
        repeat (2) @(negedge clk);
        check("m3_sck_idle", {31'd0, spi_sck}, 32'd1);
        mon_cpol = 1'b1; mon_cpha = 1'b1;
        miso_loop = 1'b0; miso_val = 1'b1;
        pb = lead_times.size(); gb = got_bits.size();
        push_bits(8'h06, 4, 1'b1);
        wr(32'h00, 32'h6);
        wait_idle("m3_done");
        check("m3_pulses", 32'(lead_times.size() - pb), 32'd4);
        cmp_bits("m3_mosi", gb, 4);
        check("m3_sck_end", {31'd0, spi_sck}, 32'd1);
        rd_chk("m3_rx", 32'h00, 32'hF);

        // DIV=0, second DATA write while busy is acked and ignored
        wr(32'h0C, 32'h0700);
        wr(32'h10, 32'd0);
        repeat (2) @(negedge clk);
        mon_cpol = 1'b0; mon_cpha = 1'b0;
        miso_loop = 1'b1;
        pb = lead_times.size(); gb = got_bits.size();
        push_bits(8'h3C, 8, 1'b0);
        wr(32'h00, 32'h3C);
        wr(32'h00, 32'hFF);
        wait_idle("d0_done");
        check("d0_pulses", 32'(lead_times.size() - pb), 32'd8);
        check("d0_span", 32'(lead_times[pb+7] - lead_times[pb]), 32'd14);
        cmp_bits("d0_mosi", gb, 8);
        rd_chk("d0_rx", 32'h00, 32'h3C);

        // Partial RX, ignored CTRL write, then reset mid-transfer
        wr(32'h10, 32'd3);
        wr(32'h08, 32'h00);
        check("cs_zero", {24'd0, spi_cs}, 32'h00);
        pb = lead_times.size();
        wr(32'h00, 32'h96);
        wait_pulses(pb, 3, 200);
        rd_chk("partial_rx", 32'h00, 32'h4);
        wr(32'h0C, 32'h0003);
        rd_chk("ctrl_busy_wr", 32'h0C, 32'h0700);
        rd_chk("status_busy", 32'h04, 32'h1);
        wr(32'h10, 32'd5);
        rd_chk("div_busy_wr", 32'h10, 32'd5);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_sck", {31'd0, spi_sck}, 32'd0);
        check("mid_rst_mosi", {31'd0, spi_mosi}, 32'd0);
        check("mid_rst_cs", {24'd0, spi_cs}, 32'hFF);
        rd_chk("mid_rst_status", 32'h04, 32'h0);
        rd_chk("mid_rst_ctrl", 32'h0C, 32'h0700);
        rd_chk("mid_rst_div", 32'h10, 32'hFF);
        rd_chk("mid_rst_rx", 32'h00, 32'h0);
        pb = lead_times.size();
        repeat (20) @(negedge clk);
        check("mid_rst_no_sck", 32'(lead_times.size() - pb), 32'd0);

        // Length saturation: len=31 on an 8-bit register
        wr(32'h0C, 32'h1F00);
        wr(32'h10, 32'd0);
        rd_chk("sat_ctrl", 32'h0C, 32'h1F00);
        pb = lead_times.size(); gb = got_bits.size();
        push_bits(8'h81, 8, 1'b0);
        wr(32'h00, 32'h81);
        wait_idle("sat_done");
        check("sat_pulses", 32'(lead_times.size() - pb), 32'd8);
        cmp_bits("sat_mosi", gb, 8);
        rd_chk("sat_rx", 32'h00, 32'h81);

        // Sticky done, cleared by STATUS read; irq enable bit
        wr(32'h0C, 32'h0708);
`ifdef WB_SPI_MODE_IRQ_EN
        rd_chk("irq_ctrl", 32'h0C, 32'h0708);
`else
        rd_chk("irq_ctrl", 32'h0C, 32'h0700);
`endif
        pb = lead_times.size();
        wr(32'h00, 32'h01);
        wait_pulses(pb, 8, 100);
        repeat (6) @(negedge clk);
`ifdef WB_SPI_MODE_IRQ_EN
        check("irq_set", {31'd0, irq}, 32'd1);
`endif
        rd_chk("done_rd", 32'h04, 32'h2);
`ifdef WB_SPI_MODE_IRQ_EN
        @(negedge clk);
        check("irq_clr", {31'd0, irq}, 32'd0);
`endif
        rd_chk("done_cleared", 32'h04, 32'h0);

        // Strobe held for 5 cycles: ack from cycle 2 onward, single access
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h08; wb_dat_i = 32'h5A;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("hold_ack", {31'd0, wb_ack_o}, (i >= 2) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
        check("hold_ack_drop", {31'd0, wb_ack_o}, 32'd0);
        rd_chk("hold_cs", 32'h08, 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
